tx_fill_sched: RTL
==================

Name: tx_fill_sched

Overview:
- Write-side controller for the transmit ping-pong frame buffers, clocked by ff_clk.
- Gates the demodulator bit stream into frames and latches a 24-bit frame ID header per frame.
- Counts payload bits and commits full frames to the PHY-side sender with a toggle handshake.
- Tracks buffer ownership: it never overwrites a buffer still being sent, and counts bits it drops.

Parameters:
ID_BITS, 24, width of frame ID header
DATA_BITS, 625, payload bits per frame (frame = ID_BITS + DATA_BITS = 649)
ADDR_W, 10, buffer bit-address width (must hold ID_BITS + DATA_BITS - 1)
DROP_W, 16, width of dropped-bit counter

Ports:
ff_clk  in  1  bit clock (~207.8 kHz)
reset  in  1  synchronous, active-high
bit_valid  in  1  demodulator bit strobe (one bit per asserted cycle)
bit_data  in  1  demodulator bit
start_req  in  1  enable framing; sampled at frame boundaries only
frameid_in  in  24  frame ID, sampled at frame start
tx_done_tgl  in  1  toggle from the phy_txclk domain; each edge = one buffer fully sent (asynchronous)
wr_en  out  1  buffer bit write strobe
wr_sel  out  1  target buffer index (0/1)
wr_addr  out  ADDR_W  bit address; LSB-first payload starts at ID_BITS
wr_bit  out  1  bit to write
hdr_we  out  1  one-cycle strobe: write hdr_data into bits [ID_BITS-1:0] of buffer wr_sel
hdr_data  out  24  latched frame ID
frame_tgl  out  1  toggles once per committed frame (to the phy_txclk domain)
buf_busy  out  2  per-buffer ownership; 1 = committed and not yet sent
overrun  out  1  one-cycle pulse per dropped bit
drop_cnt  out  DROP_W  saturating count of dropped bits

Behaviour:
- Reset (synchronous): state=IDLE, cnt=0, fill_sel=0, tx_sel=0, sync flops=0.
- All outputs reset to 0.
- Async input: tx_done_tgl passes through 2-flop synchroniser plus edge-detect flop. done_pulse = sync2 ^ sync3.
- IDLE: bit_valid is ignored (not counted as drops). Go to ARM when start_req=1.
- ARM:
  - If buf_busy[fill_sel]=0, go to FILL next cycle. Same cycle: hdr_data<=frameid_in, hdr_we=1 for one cycle, wr_sel=fill_sel, cnt=0.
  - Else stay in ARM. Each bit_valid here gives overrun=1 and drop_cnt+1, saturating at all-ones.
  - A bit_valid on the ARM->FILL transition cycle is dropped and counted.
- FILL: on each bit_valid, in the same cycle registered:
  - wr_en=1, wr_addr=ID_BITS+cnt, wr_bit=bit_data, cnt<=cnt+1.
  - When bit_valid is high and cnt==DATA_BITS-1, go to COMMIT.
  - If bit_valid=0: wr_en=0, and wr_addr/wr_bit hold their last values.
- COMMIT (exactly 1 cycle):
  - frame_tgl<=~frame_tgl, buf_busy[fill_sel]<=1, fill_sel<=~fill_sel.
  - Next state is ARM if start_req=1, else IDLE.
  - A bit_valid during COMMIT is dropped and counted.
- Release: on done_pulse, buf_busy[tx_sel]<=0 and tx_sel<=~tx_sel.
  - done_pulse in the same cycle as a COMMIT on the other buffer: apply both.
  - done_pulse when buf_busy[tx_sel]=0 (spurious): ignored, tx_sel unchanged.
- start_req dropping mid-FILL does not truncate the frame; it completes to DATA_BITS bits.
- Write latency: wr_* is registered, 1 ff_clk cycle after bit_valid.
- Header timing: hdr_we precedes the first payload wr_en by at least 1 cycle.
- Reset mid-FILL: the partial frame is abandoned; buf_busy is cleared; frame_tgl returns to 0. The PHY side must be reset together with this block.
- Arithmetic: cnt is ADDR_W bits and never exceeds DATA_BITS-1. wr_addr never exceeds ID_BITS+DATA_BITS-1.

Decomposition:
- Shared package tx_pkg:
  - constants ID_BITS, DATA_BITS, FRAME_BITS=649, ADDR_W.
  - state encoding IDLE=0, ARM=1, FILL=2, COMMIT=3.
- PHY-side sender imports the same constants.
- One sub-module: toggle_sync (2-flop synchroniser + edge detect → single-cycle pulse). Reused for frame_tgl on the phy_txclk side.

Test Plan:
- Reset, start_req=1, frameid_in=24'hABCDEF, 625 bit_valid pulses of alternating data:
  - hdr_we=1 once with hdr_data=24'hABCDEF.
  - wr_addr runs 24..648 with 625 wr_en, wr_sel=0.
  - frame_tgl goes 0→1, buf_busy=2'b01.
- Two frames back-to-back, no tx_done_tgl, 100 more bits:
  - buf_busy=2'b11, state stays ARM.
  - overrun pulses 100 times, drop_cnt=100.
- From both-busy, toggle tx_done_tgl once:
  - buf_busy[0] clears within 3 cycles.
  - FILL resumes on buffer 0, and the next bit is written at wr_addr=24.
- Deassert start_req at bit 300 of a frame:
  - all 625 bits still written, then COMMIT, then IDLE.
  - further bit_valid produce no wr_en and no drop_cnt change.
- done_pulse in the same cycle as COMMIT of buffer 1 while buffer 0 is busy: ends with buf_busy=2'b10, tx_sel=1.
- Assert reset during FILL at bit 200: the next cycle has all outputs 0 and state IDLE; the next frame starts on buffer 0 at wr_addr=24.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared constants and FSM encoding for the transmit ping-pong frame path.
// The PHY-side sender imports the same package so both sides agree on frame layout.
package tx_pkg;

   localparam int unsigned ID_BITS    = 24;
   localparam int unsigned DATA_BITS  = 625;
   localparam int unsigned FRAME_BITS = ID_BITS + DATA_BITS;
   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned DROP_W     = 16;

   // Write-side FSM encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ARM    = 2'd1;
   localparam logic [1:0] FILL   = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   // Payload is stored LSB-first directly after the header bits
   localparam logic [ADDR_W-1:0] PAYLOAD_BASE = ADDR_W'(ID_BITS);
   localparam logic [ADDR_W-1:0] LAST_CNT     = ADDR_W'(DATA_BITS - 1);

   // Saturating increment for the dropped-bit counter
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + DROP_W'(1);
   endfunction

endpackage

// File: rtl/toggle_sync.sv
// Crosses a toggle-encoded event into the local clock domain and turns each
// toggle edge into a single-cycle pulse.
module toggle_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_tgl,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   // Two synchroniser flops followed by one edge-detect flop
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_tgl;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign o_pulse = r_sync2 ^ r_sync3;

endmodule

// File: rtl/tx_fill_sched.sv
// Write-side scheduler for the transmit ping-pong frame buffers: frames the
// demodulator bit stream, writes header and payload into the free buffer,
// commits full frames to the PHY side and tracks buffer ownership.
module tx_fill_sched
   import tx_pkg::*;
(
   input  logic               ff_clk,
   input  logic               reset,
   input  logic               bit_valid,
   input  logic               bit_data,
   input  logic               start_req,
   input  logic [ID_BITS-1:0] frameid_in,
   input  logic               tx_done_tgl,
   output logic               wr_en,
   output logic               wr_sel,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic               wr_bit,
   output logic               hdr_we,
   output logic [ID_BITS-1:0] hdr_data,
   output logic               frame_tgl,
   output logic [1:0]         buf_busy,
   output logic               overrun,
   output logic [DROP_W-1:0]  drop_cnt
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_fill_sel;
   logic              r_tx_sel;

   logic [1:0]        w_state_nxt;
   logic [1:0]        w_busy_nxt;
   logic              w_done_pulse;
   logic              w_arm_go;
   logic              w_accept;
   logic              w_last;
   logic              w_commit;
   logic              w_release;
   logic              w_drop;

   toggle_sync u_done_sync (
      .i_clk   (ff_clk),
      .i_reset (reset),
      .i_tgl   (tx_done_tgl),
      .o_pulse (w_done_pulse)
   );

   assign w_arm_go  = (r_state == ARM) && !buf_busy[r_fill_sel];
   assign w_accept  = (r_state == FILL) && bit_valid;
   assign w_last    = w_accept && (r_cnt == LAST_CNT);
   assign w_commit  = (r_state == COMMIT);
   // A spurious done edge with nothing outstanding must not advance tx_sel
   assign w_release = w_done_pulse && buf_busy[r_tx_sel];
   // Bits arriving while no buffer is open (ARM, COMMIT) are lost; IDLE is not framing
   assign w_drop    = bit_valid && ((r_state == ARM) || (r_state == COMMIT));

   // Next-state decode for the framing FSM
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start_req) w_state_nxt = ARM;
         ARM:     if (w_arm_go) w_state_nxt = FILL;
         FILL:    if (w_last) w_state_nxt = COMMIT;
         COMMIT:  w_state_nxt = start_req ? ARM : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ownership update: release and commit can land in the same cycle on different buffers
   always_comb begin
      w_busy_nxt = buf_busy;
      if (w_release) w_busy_nxt[r_tx_sel] = 1'b0;
      if (w_commit) w_busy_nxt[r_fill_sel] = 1'b1;
   end

   // FSM state, payload counter and buffer pointers
   always_ff @(posedge ff_clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_fill_sel <= 1'b0;
         r_tx_sel   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_arm_go) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + ADDR_W'(1);
         end
         if (w_commit) r_fill_sel <= ~r_fill_sel;
         if (w_release) r_tx_sel <= ~r_tx_sel;
      end
   end

   // Registered buffer write port: header strobe at frame start, one payload bit per accept
   always_ff @(posedge ff_clk) begin
      if (reset) begin
         wr_en    <= 1'b0;
         wr_sel   <= 1'b0;
         wr_addr  <= '0;
         wr_bit   <= 1'b0;
         hdr_we   <= 1'b0;
         hdr_data <= '0;
      end else begin
         wr_en  <= w_accept;
         hdr_we <= w_arm_go;
         if (w_accept) begin
            wr_addr <= PAYLOAD_BASE + r_cnt;
            wr_bit  <= bit_data;
         end
         if (w_arm_go) begin
            hdr_data <= frameid_in;
            wr_sel   <= r_fill_sel;
         end
      end
   end

   // Commit handshake toward the PHY side and per-buffer ownership flags
   always_ff @(posedge ff_clk) begin
      if (reset) begin
         frame_tgl <= 1'b0;
         buf_busy  <= 2'b00;
      end else begin
         if (w_commit) frame_tgl <= ~frame_tgl;
         buf_busy <= w_busy_nxt;
      end
   end

   // Dropped-bit reporting
   always_ff @(posedge ff_clk) begin
      if (reset) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         overrun <= w_drop;
         if (w_drop) drop_cnt <= sat_inc(drop_cnt);
      end
   end

endmodule
